// File: rtl/pwm_duty_meter_if.sv
// Bundle of the enable, PWM input and measurement result signals of pwm_duty_meter.
// The master side drives ena/pwm_in and observes the results; the meter is the slave.
interface pwm_duty_meter_if #(
    parameter int unsigned CNT_W = 16
);
    logic             ena;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [3:0]       duty_tenths;
    logic             valid;
    logic             timeout;
    logic             overrun;

    modport master (
        output ena, pwm_in,
        input  high_cnt, period_cnt, duty_tenths, valid, timeout, overrun
    );

    modport slave (
        input  ena, pwm_in,
        output high_cnt, period_cnt, duty_tenths, valid, timeout, overrun
    );
endinterface

// File: rtl/pwm_duty_meter.sv
// PWM duty monitor: measures high time and period of a synchronised PWM input and
// reports floor(10*high/period) through an 11-cycle sequential divider.
module pwm_duty_meter #(
    parameter int unsigned CNT_W = 16
) (
    input logic              clk,
    input logic              rst_n,
    pwm_duty_meter_if.slave  bus
);
    localparam int unsigned TW = CNT_W + 4;
    localparam logic [CNT_W-1:0] CntMax = '1;

    typedef enum logic [1:0] {StIdle, StSync, StHigh, StLow} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
    logic             capture, to_evt, to_is_high;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] cap_period;

    logic             busy_q;
    logic [3:0]       step_q, k_q, k_next;
    logic [CNT_W-1:0] dh_q, dp_q;
    logic [TW-1:0]    tgt_q, acc_q, acc_try, tgt_new;
    logic             accept, take, div_wr;

    logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
    logic [3:0]       duty_q, duty_d;
    logic             valid_q, valid_d, timeout_q, timeout_d, overrun_q, overrun_d;
    logic             pend_q, pend_d, pend_high_q, pend_high_d, res_high;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= bus.pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        hcnt_d     = hcnt_q;
        lcnt_d     = lcnt_q;
        capture    = 1'b0;
        to_evt     = 1'b0;
        to_is_high = 1'b0;
        if (!bus.ena) begin
            state_d = StIdle;
            hcnt_d  = '0;
            lcnt_d  = '0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StSync;
                StSync: begin
                    if (rise) begin
                        state_d = StHigh;
                        hcnt_d  = CNT_W'(1);
                        lcnt_d  = '0;
                    end
                end
                StHigh: begin
                    if (fall) begin
                        state_d = StLow;
                        lcnt_d  = CNT_W'(1);
                    end else if (hcnt_q == CntMax) begin
                        to_evt     = 1'b1;
                        to_is_high = 1'b1;
                        state_d    = StSync;
                    end else begin
                        hcnt_d = hcnt_q + CNT_W'(1);
                    end
                end
                StLow: begin
                    if (rise) begin
                        capture = 1'b1;
                        state_d = StHigh;
                        hcnt_d  = CNT_W'(1);
                        lcnt_d  = '0;
                    end else if (lcnt_q == CntMax) begin
                        to_evt  = 1'b1;
                        state_d = StSync;
                    end else begin
                        lcnt_d = lcnt_q + CNT_W'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hcnt_q  <= '0;
            lcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Long high plus long low can exceed CNT_W bits; saturate the reported period.
    assign sum        = {1'b0, hcnt_q} + {1'b0, lcnt_q};
    assign cap_period = sum[CNT_W] ? CntMax : sum[CNT_W-1:0];

    assign accept  = capture & ~busy_q;
    assign tgt_new = (TW'(hcnt_q) << 3) + (TW'(hcnt_q) << 1);
    assign acc_try = acc_q + TW'(dp_q);
    assign take    = busy_q && (step_q < 4'd10) && (acc_try <= tgt_q);
    assign k_next  = k_q + {3'b000, take};
    assign div_wr  = busy_q && (step_q == 4'd9);

    // Busy spans capture+1 .. capture+11, so periods shorter than 12 overrun.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            step_q <= '0;
            dh_q   <= '0;
            dp_q   <= '0;
            tgt_q  <= '0;
            acc_q  <= '0;
            k_q    <= '0;
        end else if (!bus.ena) begin
            busy_q <= 1'b0;
            step_q <= '0;
        end else if (accept) begin
            busy_q <= 1'b1;
            step_q <= '0;
            dh_q   <= hcnt_q;
            dp_q   <= cap_period;
            tgt_q  <= tgt_new;
            acc_q  <= '0;
            k_q    <= '0;
        end else if (busy_q) begin
            if (step_q == 4'd10) begin
                busy_q <= 1'b0;
            end else begin
                step_q <= step_q + 4'd1;
            end
            if (take) begin
                acc_q <= acc_try;
                k_q   <= k_next;
            end
        end
    end

    always_comb begin
        high_d      = high_q;
        period_d    = period_q;
        duty_d      = duty_q;
        valid_d     = 1'b0;
        timeout_d   = timeout_q;
        overrun_d   = overrun_q;
        pend_d      = pend_q;
        pend_high_d = pend_high_q;
        res_high    = to_evt ? to_is_high : pend_high_q;
        if (div_wr) begin
            high_d    = dh_q;
            period_d  = dp_q;
            duty_d    = k_next;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            // A coincident stuck-input result is deferred by one cycle.
            if (to_evt) begin
                pend_d      = 1'b1;
                pend_high_d = to_is_high;
            end
        end else if (to_evt || pend_q) begin
            high_d    = res_high ? CntMax : '0;
            period_d  = CntMax;
            duty_d    = res_high ? 4'd10 : 4'd0;
            valid_d   = 1'b1;
            timeout_d = 1'b1;
            pend_d    = 1'b0;
        end
        if (!bus.ena) begin
            overrun_d = 1'b0;
            pend_d    = 1'b0;
        end else if (capture && busy_q) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q      <= '0;
            period_q    <= '0;
            duty_q      <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_high_q <= 1'b0;
        end else begin
            high_q      <= high_d;
            period_q    <= period_d;
            duty_q      <= duty_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
            pend_q      <= pend_d;
            pend_high_q <= pend_high_d;
        end
    end

    assign bus.high_cnt    = high_q;
    assign bus.period_cnt  = period_q;
    assign bus.duty_tenths = duty_q;
    assign bus.valid       = valid_q;
    assign bus.timeout     = timeout_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_pwm_duty_meter.sv
// Directed bench for pwm_duty_meter (CNT_W=8): table of PWM shapes with hand-computed
// results, plus sequences for latency, overrun, stuck input and mid-period reset.
module tb_pwm_duty_meter;
    logic clk;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    int   vcount = 0;
    int   v_cyc = 0;
    int   r_high = 0;
    int   r_period = 0;
    int   r_duty = 0;
    int   dbl = 0;
    logic prev_valid = 1'b0;

    pwm_duty_meter_if #(.CNT_W(8)) m ();

    pwm_duty_meter #(.CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_valid <= m.valid;
        if (m.valid && prev_valid) dbl <= dbl + 1;
        if (m.valid) begin
            vcount   <= vcount + 1;
            v_cyc    <= cyc;
            r_high   <= int'(m.high_cnt);
            r_period <= int'(m.period_cnt);
            r_duty   <= int'(m.duty_tenths);
        end
    end

    typedef struct {
        int h;
        int l;
        int n;
        int e_high;
        int e_per;
        int e_duty;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Hold pwm_in at v for n clock edges; called and returns at 1 ns after a posedge.
    task automatic drive(input logic v, input int n);
        m.pwm_in = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic periods(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, h);
            drive(1'b0, l);
        end
    endtask

    task automatic restart();
        m.ena = 1'b0;
        drive(1'b0, 2);
        m.ena = 1'b1;
        drive(1'b0, 4);
    endtask

    task automatic check_rec(input string tag, input int eh, input int ep, input int ed);
        check({tag, " high_cnt"}, r_high, eh);
        check({tag, " period_cnt"}, r_period, ep);
        check({tag, " duty_tenths"}, r_duty, ed);
    endtask

    initial begin
        int base;
        int start;
        vecs[0]  = '{6, 14, 4, 6, 20, 3};
        vecs[1]  = '{50, 50, 3, 50, 100, 5};
        vecs[2]  = '{80, 20, 3, 80, 100, 8};
        vecs[3]  = '{4, 36, 3, 4, 40, 1};
        vecs[4]  = '{8, 32, 3, 8, 40, 2};
        vecs[5]  = '{12, 28, 3, 12, 40, 3};
        vecs[6]  = '{16, 24, 3, 16, 40, 4};
        vecs[7]  = '{20, 20, 3, 20, 40, 5};
        vecs[8]  = '{24, 16, 3, 24, 40, 6};
        vecs[9]  = '{28, 12, 3, 28, 40, 7};
        vecs[10] = '{32, 8, 3, 32, 40, 8};
        vecs[11] = '{7, 13, 3, 7, 20, 3};
        vecs[12] = '{19, 1, 3, 19, 20, 9};

        rst_n    = 1'b0;
        m.ena    = 1'b0;
        m.pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset high_cnt", int'(m.high_cnt), 0);
        check("reset period_cnt", int'(m.period_cnt), 0);
        check("reset duty", int'(m.duty_tenths), 0);
        check("reset valid", int'(m.valid), 0);
        check("reset timeout", int'(m.timeout), 0);
        check("reset overrun", int'(m.overrun), 0);
        rst_n = 1'b1;
        drive(1'b0, 2);

        for (int i = 0; i < 13; i++) begin
            restart();
            base = vcount;
            periods(vecs[i].h, vecs[i].l, vecs[i].n);
            drive(1'b0, 20);
            check_rec($sformatf("vec%0d", i), vecs[i].e_high, vecs[i].e_per, vecs[i].e_duty);
            check($sformatf("vec%0d valid count", i), vcount - base, vecs[i].n - 1);
            check($sformatf("vec%0d timeout", i), int'(m.timeout), 0);
            check($sformatf("vec%0d overrun", i), int'(m.overrun), 0);
        end

        // Valid 11 cycles after the synchronised rise, i.e. 13 edges after pwm_in rises.
        restart();
        periods(6, 14, 1);
        base  = vcount;
        start = cyc;
        periods(6, 14, 1);
        check("latency valid count", vcount - base, 1);
        check("latency cycles", v_cyc - start, 13);
        check_rec("latency", 6, 20, 3);

        restart();
        periods(50, 50, 3);
        check("switch 50/50 duty", r_duty, 5);
        periods(80, 20, 3);
        drive(1'b0, 20);
        check_rec("switch 80/20", 80, 100, 8);
        check("switch overrun", int'(m.overrun), 0);

        // Period 8 lands captures inside the divider window: every other one dropped.
        restart();
        base = vcount;
        periods(4, 4, 6);
        drive(1'b0, 20);
        check("overrun set", int'(m.overrun), 1);
        check("overrun valid count", vcount - base, 3);
        check_rec("overrun", 4, 8, 5);
        m.ena = 1'b0;
        drive(1'b0, 1);
        check("overrun cleared by ena", int'(m.overrun), 0);
        check("ena low keeps duty", int'(m.duty_tenths), 5);
        m.ena = 1'b1;
        drive(1'b0, 4);
        periods(6, 14, 3);
        drive(1'b0, 20);
        check("restart overrun", int'(m.overrun), 0);
        check("restart duty", r_duty, 3);

        restart();
        base = vcount;
        drive(1'b1, 300);
        check("stuck high valid count", vcount - base, 1);
        check("stuck high timeout", int'(m.timeout), 1);
        check_rec("stuck high", 255, 255, 10);
        drive(1'b0, 14);
        periods(6, 14, 3);
        drive(1'b0, 20);
        check("resume timeout", int'(m.timeout), 0);
        check_rec("resume", 6, 20, 3);

        restart();
        drive(1'b1, 6);
        base = vcount;
        drive(1'b0, 300);
        check("stuck low valid count", vcount - base, 1);
        check("stuck low timeout", int'(m.timeout), 1);
        check_rec("stuck low", 0, 255, 0);

        restart();
        periods(6, 14, 2);
        drive(1'b1, 3);
        check("pre-reset duty", int'(m.duty_tenths), 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset duty", int'(m.duty_tenths), 0);
        check("async reset period", int'(m.period_cnt), 0);
        check("async reset high", int'(m.high_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base  = vcount;
        drive(1'b1, 3);
        drive(1'b0, 14);
        check("no valid after reset", vcount - base, 0);
        periods(6, 14, 3);
        drive(1'b0, 20);
        check_rec("after reset", 6, 20, 3);

        check("valid single-cycle", dbl, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
